// File: rtl/reg_mem.sv
// reg_mem: single-port register-file memory of 2**ADDR_BITS words, DATA_WIDTH bits each.
// One shared address bus serves both the synchronous write and the registered read.
// A synchronous active-low reset clears every word and the read register.
// A write also returns the written data on data_out in the same cycle (write-first).
module reg_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rst_n
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: reset clears all words and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wen) begin
            mem[addr] <= data_in;
        end
    end

    // Read register: write-first on a write cycle, otherwise the addressed word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (wen) begin
            data_out <= data_in;
        end else begin
            data_out <= mem[addr];
        end
    end

endmodule

// File: tb/tb_reg_mem.sv
// tb_reg_mem: self-checking bench for reg_mem.
// Runs a table of directed vectors, a few hand-written timing sequences,
// and then randomized traffic compared against a simple array model.
module tb_reg_mem;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          wen;
    logic          clk;
    logic [DW-1:0] data_out;
    logic          rst_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rst_n;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data_in;
        logic [DW-1:0] exp_out;
        string         name;
    } vec_t;

    vec_t vecs[$];

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;

    reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
        .addr     (addr),
        .data_in  (data_in),
        .wen      (wen),
        .clk      (clk),
        .data_out (data_out),
        .rst_n    (rst_n)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add_vec(input logic r, input logic w, input int a,
                                    input logic [DW-1:0] d, input logic [DW-1:0] e,
                                    input string n);
        vec_t v;
        v.rst_n   = r;
        v.wen     = w;
        v.addr    = AW'(a % DEPTH);
        v.data_in = d;
        v.exp_out = e;
        v.name    = n;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] exp);
        total++;
        if (data_out !== exp) begin
            bad++;
            $display("[TB] FAIL %s: data_out=%h expected=%h", name, data_out, exp);
        end
    endtask

    // Drive inputs away from the edge, then let one rising edge happen and settle.
    task automatic apply_stimulus(input logic r, input logic w,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst_n   = r;
        wen     = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one edge of the memory described in plain terms.
    function automatic void model_step(input logic r, input logic w,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!r) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ref_out = '0;
        end else if (w) begin
            ref_mem[int'(a)] = d;
            ref_out = d;
        end else begin
            ref_out = ref_mem[int'(a)];
        end
    endfunction

    initial begin
        int wrap_a;
        rst_n   = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        data_in = '0;

        // Directed table: reset, clear reads, fill, readback, wrap, overwrite.
        add_vec(0, 0, 0, 8'h00, 8'h00, "reset");
        for (int a = 0; a < 32; a++)
            add_vec(1, 0, a, 8'h5A, 8'h00, $sformatf("clear_rd%0d", a));
        for (int i = 10; i <= 29; i++)
            add_vec(1, 1, i + 2, DW'(i), DW'(i), $sformatf("fill_wr%0d", i + 2));
        for (int a = 12; a <= 31; a++)
            add_vec(1, 0, a, 8'hC3, DW'(a - 2), $sformatf("fill_rd%0d", a));
        wrap_a = 32;
        add_vec(1, 1, wrap_a, 8'd30, 8'd30, "wrap_wr32");
        wrap_a = 33;
        add_vec(1, 1, wrap_a, 8'd31, 8'd31, "wrap_wr33");
        add_vec(1, 0, 0, 8'h00, 8'd30, "wrap_rd0");
        add_vec(1, 0, 1, 8'h00, 8'd31, "wrap_rd1");
        add_vec(1, 0, 12, 8'h00, 8'd10, "wrap_rd12");
        add_vec(1, 1, 31, 8'hFF, 8'hFF, "ovw_wr31");
        add_vec(1, 0, 31, 8'h00, 8'hFF, "ovw_rd31");
        add_vec(1, 0, 30, 8'h00, 8'd28, "ovw_rd30");
        add_vec(1, 1, 7, 8'h3C, 8'h3C, "b2b_wr7");
        add_vec(1, 0, 7, 8'h00, 8'h3C, "b2b_rd7");
        add_vec(1, 1, 8, 8'h99, 8'h99, "b2b_wr8");
        add_vec(1, 0, 8, 8'h00, 8'h99, "b2b_rd8");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].wen, vecs[i].addr, vecs[i].data_in);
            check_output(vecs[i].name, vecs[i].exp_out);
        end

        // Latency/hold: address change between edges must not reach data_out.
        apply_stimulus(1, 0, 5'd12, 8'h00);
        check_output("hold_rd12", 8'd10);
        @(negedge clk);
        addr = 5'd13;
        #2;
        check_output("hold_between_edges", 8'd10);
        @(posedge clk);
        #1;
        check_output("hold_rd13", 8'd11);

        // Reset priority: a write during reset is dropped and old contents vanish.
        apply_stimulus(0, 1, 5'd5, 8'hA5);
        check_output("rstprio_out", 8'h00);
        apply_stimulus(1, 0, 5'd5, 8'h00);
        check_output("rstprio_rd5", 8'h00);
        apply_stimulus(1, 0, 5'd12, 8'h00);
        check_output("rstprio_rd12", 8'h00);

        // Randomized traffic against the model, starting from a known reset.
        apply_stimulus(0, 0, '0, '0);
        model_step(0, 0, '0, '0);
        check_output("rand_reset", ref_out);
        for (int n = 0; n < 600; n++) begin
            logic          r;
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 49) != 0);
            w = $urandom_range(0, 1) == 1;
            a = AW'($urandom);
            d = DW'($urandom);
            apply_stimulus(r, w, a, d);
            model_step(r, w, a, d);
            check_output($sformatf("rand%0d_a%0d_w%0d_r%0d", n, a, w, r), ref_out);
        end

        // Final sweep: every location must match the model.
        for (int a = 0; a < DEPTH; a++) begin
            apply_stimulus(1, 0, AW'(a), 8'hEE);
            model_step(1, 0, AW'(a), 8'hEE);
            check_output($sformatf("sweep_rd%0d", a), ref_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
